// File: rtl/wb_gain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wb_gain_ctrl
// Description : Gray-world auto-white-balance gain controller. Accumulates
//               per-channel pixel sums over a frame, then divides sequentially
//               (restoring, one quotient bit per cycle) to get
//               gain_r = sumG/sumR and gain_b = sumG/sumB. The gains are
//               published once per frame during vertical blank.
// Options     : define WB_GAIN_IIR_EN to smooth published gains with a
//               first-order IIR filter (new = old + (calc - old)/4).
// Revision    : 1.0 - initial release
// ============================================================================
module wb_gain_ctrl #(
  parameter int G_DATA_WIDTH = 8,
  parameter int G_COEF_WIDTH = 8,
  parameter int G_FRAC_WIDTH = 4,
  parameter int G_ACC_WIDTH  = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic                    frame_start_i,
  input  logic                    frame_end_i,
  input  logic                    data_valid_i,
  input  logic [G_DATA_WIDTH-1:0] r_i,
  input  logic [G_DATA_WIDTH-1:0] g_i,
  input  logic [G_DATA_WIDTH-1:0] b_i,
  output logic [G_COEF_WIDTH-1:0] gain_r_o,
  output logic [G_COEF_WIDTH-1:0] gain_g_o,
  output logic [G_COEF_WIDTH-1:0] gain_b_o,
  output logic                    update_o,
  output logic                    busy_o
);

  localparam int REM_W = G_ACC_WIDTH + G_FRAC_WIDTH;  // dividend/remainder
  localparam int QUO_W = G_COEF_WIDTH + 1;            // quotient incl. overflow bit
  localparam int CNT_W = $clog2(QUO_W);

  localparam logic [G_COEF_WIDTH-1:0] C_UNITY    = {{(G_COEF_WIDTH-1){1'b0}}, 1'b1} << G_FRAC_WIDTH;
  localparam logic [CNT_W-1:0]        C_LAST_BIT = CNT_W'(G_COEF_WIDTH);
  localparam logic [G_ACC_WIDTH-1:0]  C_ACC_ONE  = {{(G_ACC_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCUM  = 3'd1,
    S_DIV_R  = 3'd2,
    S_DIV_B  = 3'd3,
    S_UPDATE = 3'd4
  } state_t;

  state_t r_state, w_state_nxt;

  logic [G_ACC_WIDTH-1:0]  r_sum_r, r_sum_g, r_sum_b, r_pix_cnt, w_cnt_nxt;
  logic [REM_W-1:0]        r_rem, w_rem_cur, w_rem_nxt, w_divisor_ext, w_dvd_hi_ext;
  logic [REM_W:0]          w_trial;
  logic [QUO_W-2:0]        r_quo;
  logic [QUO_W-1:0]        w_quo_nxt;
  logic [CNT_W-1:0]        r_bit;
  logic                    r_ovf, w_ovf, w_sat, w_ge, w_first, w_last;
  logic                    w_clear, w_add, w_div_active;
  logic [G_ACC_WIDTH-1:0]  w_divisor;
  logic [REM_W-1:0]        w_dividend;
  logic [QUO_W-1:0]        w_dvd_lo;
  logic [G_COEF_WIDTH-1:0] r_calc_r, w_calc, r_gain_r, r_gain_b;

  // Accumulator add that sticks at all-ones instead of wrapping.
  function automatic logic [G_ACC_WIDTH-1:0] sat_add(input logic [G_ACC_WIDTH-1:0] a,
                                                     input logic [G_ACC_WIDTH-1:0] b);
    logic [G_ACC_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[G_ACC_WIDTH] ? {G_ACC_WIDTH{1'b1}} : s[G_ACC_WIDTH-1:0];
  endfunction

`ifdef WB_GAIN_IIR_EN
  // One IIR step: cur + ((calc - cur) >>> 2) with a signed difference.
  function automatic logic [G_COEF_WIDTH-1:0] iir_step(input logic [G_COEF_WIDTH-1:0] cur,
                                                       input logic [G_COEF_WIDTH-1:0] calc);
    logic signed [G_COEF_WIDTH:0] diff;
    diff = $signed({1'b0, calc}) - $signed({1'b0, cur});
    diff = diff >>> 2;
    return cur + diff[G_COEF_WIDTH-1:0];
  endfunction
`endif

  // Frame bookkeeping: when sums restart and when a pixel is taken.
  always_comb begin
    w_clear   = enable_i && frame_start_i && ((r_state == S_IDLE) || (r_state == S_ACCUM));
    w_add     = (r_state == S_ACCUM) && enable_i && !frame_start_i && data_valid_i;
    w_cnt_nxt = w_add ? sat_add(r_pix_cnt, C_ACC_ONE) : r_pix_cnt;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; a pixel coincident with frame_end is counted via w_cnt_nxt.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (enable_i && frame_start_i) w_state_nxt = S_ACCUM;
      S_ACCUM: begin
        if (!enable_i)        w_state_nxt = S_IDLE;
        else if (frame_start_i) w_state_nxt = S_ACCUM;
        else if (frame_end_i) w_state_nxt = (w_cnt_nxt == '0) ? S_IDLE : S_DIV_R;
      end
      S_DIV_R:  if (w_last) w_state_nxt = S_DIV_B;
      S_DIV_B:  if (w_last) w_state_nxt = S_UPDATE;
      S_UPDATE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Per-channel sums and pixel count; frozen outside ACCUM.
  always_ff @(posedge clk_i) begin
    if (rst_i || w_clear) begin
      r_sum_r   <= '0;
      r_sum_g   <= '0;
      r_sum_b   <= '0;
      r_pix_cnt <= '0;
    end else if (w_add) begin
      r_sum_r   <= sat_add(r_sum_r, {{(G_ACC_WIDTH-G_DATA_WIDTH){1'b0}}, r_i});
      r_sum_g   <= sat_add(r_sum_g, {{(G_ACC_WIDTH-G_DATA_WIDTH){1'b0}}, g_i});
      r_sum_b   <= sat_add(r_sum_b, {{(G_ACC_WIDTH-G_DATA_WIDTH){1'b0}}, b_i});
      r_pix_cnt <= w_cnt_nxt;
    end
  end

  // One restoring-divide step. The dividend bits above the quotient window seed
  // the remainder on the first step; if they already reach the divisor the
  // quotient cannot fit and the result saturates.
  always_comb begin
    w_div_active  = (r_state == S_DIV_R) || (r_state == S_DIV_B);
    w_first       = (r_bit == C_LAST_BIT);
    w_last        = (r_bit == '0);
    w_divisor     = (r_state == S_DIV_B) ? r_sum_b : r_sum_r;
    w_divisor_ext = {{G_FRAC_WIDTH{1'b0}}, w_divisor};
    w_dividend    = {r_sum_g, {G_FRAC_WIDTH{1'b0}}};
    w_dvd_lo      = w_dividend[QUO_W-1:0];
    w_dvd_hi_ext  = {{QUO_W{1'b0}}, w_dividend[REM_W-1:QUO_W]};
    w_rem_cur     = w_first ? w_dvd_hi_ext : r_rem;
    w_trial       = {w_rem_cur, w_dvd_lo[r_bit]};
    w_ge          = (w_trial >= {1'b0, w_divisor_ext});
    w_rem_nxt     = REM_W'(w_ge ? (w_trial - {1'b0, w_divisor_ext}) : w_trial);
    w_quo_nxt     = {r_quo, w_ge};
    w_ovf         = w_first ? (w_dvd_hi_ext >= w_divisor_ext) : r_ovf;
    w_sat         = w_ovf || w_quo_nxt[QUO_W-1] || (w_divisor == '0);
    w_calc        = w_sat ? {G_COEF_WIDTH{1'b1}} : w_quo_nxt[G_COEF_WIDTH-1:0];
  end

  // Divider iteration registers; the bit counter re-arms for each divide.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rem    <= '0;
      r_quo    <= '0;
      r_ovf    <= 1'b0;
      r_bit    <= C_LAST_BIT;
      r_calc_r <= '0;
    end else if (w_div_active) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt[QUO_W-2:0];
      r_ovf <= w_ovf;
      if (w_last) begin
        r_bit <= C_LAST_BIT;
        if (r_state == S_DIV_R) r_calc_r <= w_calc;
      end else begin
        r_bit <= r_bit - 1'b1;
      end
    end else begin
      r_bit <= C_LAST_BIT;
    end
  end

  // Published gains change only on the edge that enters UPDATE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_gain_r <= C_UNITY;
      r_gain_b <= C_UNITY;
    end else if ((r_state == S_DIV_B) && w_last) begin
`ifdef WB_GAIN_IIR_EN
      r_gain_r <= iir_step(r_gain_r, r_calc_r);
      r_gain_b <= iir_step(r_gain_b, w_calc);
`else
      r_gain_r <= r_calc_r;
      r_gain_b <= w_calc;
`endif
    end
  end

  assign gain_r_o = r_gain_r;
  assign gain_g_o = C_UNITY;
  assign gain_b_o = r_gain_b;
  assign update_o = (r_state == S_UPDATE);
  assign busy_o   = (r_state == S_DIV_R) || (r_state == S_DIV_B) || (r_state == S_UPDATE);

endmodule
`default_nettype wire

// File: tb/tb_wb_gain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_gain_ctrl
// Description : Self-checking bench for wb_gain_ctrl. Frames are generated
//               with $urandom and fixed patterns; expected gains come from a
//               plain-arithmetic gray-world model (honours WB_GAIN_IIR_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_gain_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i, enable_i, frame_start_i, frame_end_i, data_valid_i;
  logic [7:0] r_i, g_i, b_i;
  logic [7:0] gain_r_o, gain_g_o, gain_b_o;
  logic       update_o, busy_o;

  int n_checks = 0;
  int n_errors = 0;
  int exp_r = 16;
  int exp_b = 16;
  int pr[$];
  int pg[$];
  int pb[$];

  always #5 clk_i = ~clk_i;

  wb_gain_ctrl #(
    .G_DATA_WIDTH(8), .G_COEF_WIDTH(8), .G_FRAC_WIDTH(4), .G_ACC_WIDTH(32)
  ) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
    .frame_start_i(frame_start_i), .frame_end_i(frame_end_i),
    .data_valid_i(data_valid_i), .r_i(r_i), .g_i(g_i), .b_i(b_i),
    .gain_r_o(gain_r_o), .gain_g_o(gain_g_o), .gain_b_o(gain_b_o),
    .update_o(update_o), .busy_o(busy_o)
  );

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Gray-world gain in Q4.4: floor(16*num/den), saturated.
  function automatic int ref_gain(input longint num, input longint den);
    longint q;
    if (den == 0) return 255;
    q = (num * 16) / den;
    return (q > 255) ? 255 : int'(q);
  endfunction

  function automatic int ref_filter(input int cur, input int calc);
`ifdef WB_GAIN_IIR_EN
    int d;
    d = calc - cur;
    return cur + (d >>> 2);
`else
    return calc;
`endif
  endfunction

  // Expected published gains after the frame currently held in the queues.
  task automatic ref_update;
    longint sr, sg, sb, lim;
    lim = 64'hFFFF_FFFF;
    sr = 0; sg = 0; sb = 0;
    foreach (pr[i]) begin
      sr = (sr + pr[i] > lim) ? lim : sr + pr[i];
      sg = (sg + pg[i] > lim) ? lim : sg + pg[i];
      sb = (sb + pb[i] > lim) ? lim : sb + pb[i];
    end
    if (pr.size() != 0) begin
      exp_r = ref_filter(exp_r, ref_gain(sg, sr));
      exp_b = ref_filter(exp_b, ref_gain(sg, sb));
    end
  endtask

  task automatic fill(input int n, input int rv, input int gv, input int bv);
    pr.delete(); pg.delete(); pb.delete();
    for (int i = 0; i < n; i++) begin
      pr.push_back(rv < 0 ? int'($urandom_range(0, 255)) : rv);
      pg.push_back(gv < 0 ? int'($urandom_range(0, 255)) : gv);
      pb.push_back(bv < 0 ? int'($urandom_range(0, 255)) : bv);
    end
  endtask

  // Drive the queued frame, with random idle gaps carrying junk data.
  task automatic drive_frame(input bit coincident);
    frame_start_i = 1'b1; data_valid_i = 1'b0; tick; frame_start_i = 1'b0;
    foreach (pr[i]) begin
      if ($urandom_range(0, 3) == 0) begin
        data_valid_i = 1'b0;
        r_i = 8'($urandom); g_i = 8'($urandom); b_i = 8'($urandom);
        tick;
      end
      data_valid_i = 1'b1;
      r_i = 8'(pr[i]); g_i = 8'(pg[i]); b_i = 8'(pb[i]);
      frame_end_i = coincident && (i == pr.size() - 1);
      tick;
    end
    data_valid_i = 1'b0;
    if (!coincident || pr.size() == 0) begin
      frame_end_i = 1'b1; tick;
    end
    frame_end_i = 1'b0;
  endtask

  // Called in the cycle after frame_end was sampled (cycle 1 of the divide).
  task automatic wait_update(input bit inject);
    int         lat;
    bit         stable;
    logic [7:0] gr0, gb0;
    gr0 = gain_r_o; gb0 = gain_b_o; stable = 1'b1; lat = 1;
    check("busy_after_frame_end", busy_o, 1);
    while (!update_o && lat < 40) begin
      if (gain_r_o != gr0 || gain_b_o != gb0) stable = 1'b0;
      if (inject) begin
        frame_start_i = (lat == 3);
        data_valid_i  = (lat >= 4 && lat <= 8);
        r_i = 8'd1; g_i = 8'd255; b_i = 8'd1;
        frame_end_i   = (lat == 9);
      end
      tick;
      lat++;
    end
    frame_start_i = 1'b0; data_valid_i = 1'b0; frame_end_i = 1'b0;
    check("update_latency", lat, 19);
    check("gains_stable_while_busy", stable, 1);
    check("gain_r", gain_r_o, exp_r);
    check("gain_b", gain_b_o, exp_b);
    check("gain_g", gain_g_o, 16);
    tick;
    check("update_pulse_width", update_o, 0);
  endtask

  task automatic quiet(input int n, output bit seen_busy, output bit seen_upd);
    seen_busy = busy_o; seen_upd = update_o;
    repeat (n) begin
      tick;
      seen_busy |= busy_o;
      seen_upd  |= update_o;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit sb, su;
    rst_i = 1'b1; enable_i = 1'b1; frame_start_i = 1'b0; frame_end_i = 1'b0;
    data_valid_i = 1'b0; r_i = '0; g_i = '0; b_i = '0;
    repeat (3) tick;
    check("reset_gain_r", gain_r_o, 16);
    check("reset_gain_g", gain_g_o, 16);
    check("reset_gain_b", gain_b_o, 16);
    check("reset_update", update_o, 0);
    check("reset_busy", busy_o, 0);
    rst_i = 1'b0;
    tick;

    // Fixed pattern: gains 0x20 / 0x40 (0x14 / 0x1C when filtered).
    fill(16, 64, 128, 32);
    drive_frame(1'b0); ref_update; wait_update(1'b0);

    // Divisor zero on red, then quotient overflow on red.
    fill(8, 0, 100, 100);
    drive_frame(1'b0); ref_update; wait_update(1'b0);
    fill(5, 1, 255, -1);
    drive_frame(1'b0); ref_update; wait_update(1'b0);

    // Empty frame: no divide, no update.
    fill(0, 0, 0, 0);
    drive_frame(1'b0);
    quiet(25, sb, su);
    check("empty_frame_busy", sb, 0);
    check("empty_frame_update", su, 0);
    check("empty_frame_gain_r", gain_r_o, exp_r);

    // A whole frame presented while busy must be ignored.
    fill(10, -1, -1, -1);
    drive_frame(1'b0); ref_update; wait_update(1'b1);

    // Last pixel arrives with frame_end and has distinctive values.
    fill(3, 10, 20, 40);
    pr.push_back(200); pg.push_back(7); pb.push_back(3);
    drive_frame(1'b1); ref_update; wait_update(1'b0);

    // Random frames.
    for (int k = 0; k < 6; k++) begin
      fill($urandom_range(1, 24), (k == 2) ? 0 : -1, -1, -1);
      drive_frame(1'($urandom_range(0, 1))); ref_update; wait_update(1'b0);
    end

    // Reset in the middle of the blue divide.
    fill(12, -1, -1, -1);
    drive_frame(1'b0);
    repeat (11) tick;
    check("busy_before_mid_reset", busy_o, 1);
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    exp_r = 16; exp_b = 16;
    check("mid_reset_gain_r", gain_r_o, 16);
    check("mid_reset_gain_b", gain_b_o, 16);
    check("mid_reset_busy", busy_o, 0);
    check("mid_reset_update", update_o, 0);
    quiet(25, sb, su);
    check("after_reset_no_update", su, 0);

    // Auto mode disabled for a full frame.
    enable_i = 1'b0;
    fill(10, 30, 200, 90);
    drive_frame(1'b0);
    quiet(25, sb, su);
    check("disabled_busy", sb, 0);
    check("disabled_update", su, 0);
    check("disabled_gain_b", gain_b_o, exp_b);
    enable_i = 1'b1;
    tick;

    // Recovery frame.
    fill(16, -1, -1, -1);
    drive_frame(1'b0); ref_update; wait_update(1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_gain_ctrl.md
Name: wb_gain_ctrl

Overview:
Auto-white-balance gain controller for the per-channel white-balance cores. It accumulates R/G/B pixel sums over one frame. At frame end it runs a sequential restoring divider to compute gray-world gains (gain_r = sumG/sumR, gain_b = sumG/sumB, gain_g = 1.0). It then publishes those gains in the core's unsigned fixed-point gain format, once per frame, during vertical blank.

Parameters:
G_DATA_WIDTH, 8, pixel component width
G_COEF_WIDTH, 8, gain output width (unsigned fixed point)
G_FRAC_WIDTH, 4, fractional bits of gain; unity gain = 1<<G_FRAC_WIDTH
G_ACC_WIDTH, 32, per-channel accumulator width

Ports:
clk_i  in  1  system/pixel clock
rst_i  in  1  synchronous active-high reset
enable_i  in  1  1 = auto mode active; 0 = hold current gains, FSM stays IDLE
frame_start_i  in  1  single-cycle pulse, first pixel of frame follows
frame_end_i  in  1  single-cycle pulse, frame finished (vertical blank begins)
data_valid_i  in  1  pixel qualifier
r_i  in  G_DATA_WIDTH  red component
g_i  in  G_DATA_WIDTH  green component
b_i  in  G_DATA_WIDTH  blue component
gain_r_o  out  G_COEF_WIDTH  red gain
gain_g_o  out  G_COEF_WIDTH  green gain (always unity)
gain_b_o  out  G_COEF_WIDTH  blue gain
update_o  out  1  one-cycle pulse, gains changed this cycle
busy_o  out  1  high in DIV_R, DIV_B, UPDATE

Behaviour:
- Clock/reset: one clock clk_i; rst_i is synchronous, active-high. Reset applies to every register.
- Reset values: gain_r_o = gain_g_o = gain_b_o = 1<<G_FRAC_WIDTH; update_o = 0; busy_o = 0; state IDLE; accumulators and pixel count = 0.
- States:
  - IDLE: frame_start_i && enable_i -> clear sums and pixel count -> ACCUM.
  - ACCUM: each data_valid_i adds r/g/b to sumR/sumG/sumB and increments the pixel count. Each accumulator saturates at all-ones and does not wrap.
  - ACCUM, frame_start_i again: clear and restart accumulation.
  - ACCUM, frame_end_i: -> DIV_R, or -> IDLE with no update if the pixel count is 0.
  - ACCUM, enable_i low: -> IDLE, sums discarded.
  - data_valid_i together with frame_end_i in the same cycle: that pixel is included.
  - DIV_R: restoring divide of (sumG << G_FRAC_WIDTH) by sumR. Produces G_COEF_WIDTH+1 quotient bits, one bit per cycle, MSB first. Takes exactly G_COEF_WIDTH+1 cycles, then -> DIV_B.
  - DIV_B: same operation with divisor sumB, same cycle count, then -> UPDATE.
  - UPDATE: gain outputs load and update_o = 1 for this one cycle; -> IDLE.
- Divider width: internal dividend/remainder of G_ACC_WIDTH+G_FRAC_WIDTH bits. Quotient is truncated, not rounded.
- Saturation: if quotient bit G_COEF_WIDTH is set, or the divisor is 0, the gain is all-ones (0xFF at defaults).
- Latency: update_o asserts exactly 2*(G_COEF_WIDTH+1)+1 cycles after the cycle frame_end_i is sampled in ACCUM (19 cycles at defaults).
- Events while busy: frame_start_i, frame_end_i and data_valid_i are ignored in DIV_R/DIV_B/UPDATE; that frame is skipped. enable_i falling while busy does not abort the calculation.
- Output stability: gain outputs change only in the UPDATE cycle and are otherwise stable.
- Reset mid-operation: rst_i during any state returns all outputs to reset values on the next edge. A partial result is never published.

Optional Feature:
WB_GAIN_IIR_EN:
- Defined: UPDATE loads gain_o <= gain_o + ((calc - gain_o) >>> 2). The difference is signed, G_COEF_WIDTH+1 bits, arithmetic shift. This gives temporal smoothing and removes flicker. The saturation rule applies to calc before filtering. Latency is unchanged.
- Undefined: UPDATE loads calc directly.

Test Plan:
1. Reset, then sample outputs -> gains 0x10/0x10/0x10, update_o = 0, busy_o = 0.
2. Frame of 16 valid pixels r=64, g=128, b=32 -> update_o exactly 19 cycles after frame_end_i; gain_r_o = 0x20, gain_b_o = 0x40, gain_g_o = 0x10. With WB_GAIN_IIR_EN defined: gain_r_o = 0x14, gain_b_o = 0x1C.
3. Frame with all r=0, g=100, b=100 -> gain_r_o = 0xFF (divisor-zero saturation), gain_b_o = 0x10. Separate frame r=1, g=255 -> gain_r_o = 0xFF (overflow).
4. frame_end_i with no valid pixels since frame_start_i -> no update_o, gains unchanged, busy_o never asserted.
5. frame_start_i + pixels + frame_end_i presented during busy_o -> ignored. The next full frame gives the correct result; data_valid_i coincident with frame_end_i is counted (verify with one odd pixel value).
6. rst_i asserted mid DIV_B -> next cycle gains = 0x10, busy_o = 0, no update_o pulse. enable_i = 0 for a full frame -> no update.
